// File: rtl/ex_ctrl_pkg.sv
// Shared exception-controller definitions: exception codes, entry vector,
// CP0 field positions, FSM state type and the interrupt-pending helper.
package ex_ctrl_pkg;

  localparam logic [4:0]  NO_EX     = 5'h1f;
  localparam logic [4:0]  EXC_INT   = 5'h00;
  localparam logic [4:0]  EXC_ADEL  = 5'h04;
  localparam logic [4:0]  EXC_ADES  = 5'h05;
  localparam logic [4:0]  EXC_SYS   = 5'h08;
  localparam logic [4:0]  EXC_BP    = 5'h09;
  localparam logic [4:0]  EXC_RI    = 5'h0a;
  localparam logic [4:0]  EXC_OV    = 5'h0c;

  localparam logic [31:0] EX_VECTOR = 32'hBFC0_0380;

  // CP0 Status / Cause field positions
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_LO      = 8;
  localparam int IM_HI      = 15;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  // An interrupt is taken when any unmasked line is pending, interrupts are
  // globally enabled and the core is not already at exception level.
  function automatic logic int_pending(input logic [7:0] im, input logic [7:0] ip,
                                       input logic ie, input logic exl);
    int_pending = (|(im & ip)) & ie & ~exl;
  endfunction

endpackage

// File: rtl/ex_ctrl_if.sv
// WB-stage event inputs, CP0 commit outputs and fetch-redirect handshake.
interface ex_ctrl_if;
  import ex_ctrl_pkg::*;

  logic        ws_valid;
  logic [4:0]  ws_ex_code;
  logic        ws_eret;
  logic [31:0] ws_pc;
  logic [31:0] ws_badvaddr;
  logic        ws_slot;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic [4:0]  cp0_ex_code;
  logic        cp0_eret;
  logic        cp0_slot;
  logic        cp0_pc_error;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_badvaddr;
  logic        ws_cancel;
  logic        flush;
  logic [31:0] flush_pc;
  logic        flush_ready;

  modport slave (
    input  ws_valid, ws_ex_code, ws_eret, ws_pc, ws_badvaddr, ws_slot,
    input  cp0_status, cp0_cause, cp0_epc, flush_ready,
    output cp0_ex_code, cp0_eret, cp0_slot, cp0_pc_error, cp0_wdata,
    output cp0_badvaddr, ws_cancel, flush, flush_pc
  );

  modport master (
    output ws_valid, ws_ex_code, ws_eret, ws_pc, ws_badvaddr, ws_slot,
    output cp0_status, cp0_cause, cp0_epc, flush_ready,
    input  cp0_ex_code, cp0_eret, cp0_slot, cp0_pc_error, cp0_wdata,
    input  cp0_badvaddr, ws_cancel, flush, flush_pc
  );

endinterface

// File: rtl/ex_ctrl.sv
// Exception/ERET controller: captures a WB-stage event, strobes CP0 for one
// cycle, then holds a fetch redirect until fetch accepts it. All outputs are
// driven straight from registers.
module ex_ctrl
  import ex_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  ex_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [4:0]  cp0_ex_code_q, cp0_ex_code_d;
  logic        cp0_eret_q, cp0_eret_d;
  logic        cp0_slot_q, cp0_slot_d;
  logic        cp0_pc_error_q, cp0_pc_error_d;
  logic [31:0] cp0_wdata_q, cp0_wdata_d;
  logic [31:0] cp0_badvaddr_q, cp0_badvaddr_d;
  logic        ws_cancel_q, ws_cancel_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic        int_req_s;
  logic        event_s;
  logic        cp0_bits_unused;

  assign int_req_s = int_pending(bus.cp0_status[IM_HI:IM_LO], bus.cp0_cause[IM_HI:IM_LO],
                                 bus.cp0_status[STATUS_IE], bus.cp0_status[STATUS_EXL]);
  assign event_s   = int_req_s | (bus.ws_ex_code != NO_EX) | bus.ws_eret;

  // Only the interrupt-related Status/Cause fields matter here.
  assign cp0_bits_unused = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                             bus.cp0_cause[31:16], bus.cp0_cause[7:0]};

  // State and output registers; reset aborts any commit or redirect at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cp0_ex_code_q  <= NO_EX;
      cp0_eret_q     <= 1'b0;
      cp0_slot_q     <= 1'b0;
      cp0_pc_error_q <= 1'b0;
      cp0_wdata_q    <= 32'h0000_0000;
      cp0_badvaddr_q <= 32'h0000_0000;
      ws_cancel_q    <= 1'b0;
      flush_q        <= 1'b0;
      flush_pc_q     <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      cp0_ex_code_q  <= cp0_ex_code_d;
      cp0_eret_q     <= cp0_eret_d;
      cp0_slot_q     <= cp0_slot_d;
      cp0_pc_error_q <= cp0_pc_error_d;
      cp0_wdata_q    <= cp0_wdata_d;
      cp0_badvaddr_q <= cp0_badvaddr_d;
      ws_cancel_q    <= ws_cancel_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  // Next state and next output values; CP0 strobes only live for one cycle.
  always_comb begin
    state_d        = state_q;
    cp0_ex_code_d  = NO_EX;
    cp0_eret_d     = 1'b0;
    cp0_slot_d     = 1'b0;
    cp0_pc_error_d = 1'b0;
    cp0_wdata_d    = cp0_wdata_q;
    cp0_badvaddr_d = cp0_badvaddr_q;
    ws_cancel_d    = ws_cancel_q;
    flush_d        = flush_q;
    flush_pc_d     = flush_pc_q;
    case (state_q)
      S_IDLE: begin
        ws_cancel_d = 1'b0;
        flush_d     = 1'b0;
        if (bus.ws_valid && event_s) begin
          state_d        = S_COMMIT;
          ws_cancel_d    = 1'b1;
          cp0_wdata_d    = bus.ws_pc;
          cp0_badvaddr_d = bus.ws_badvaddr;
          cp0_slot_d     = bus.ws_slot;
          // interrupt beats a synchronous exception, which beats ERET
          if (int_req_s) begin
            cp0_ex_code_d = EXC_INT;
          end else if (bus.ws_ex_code != NO_EX) begin
            cp0_ex_code_d = bus.ws_ex_code;
          end else begin
            cp0_eret_d = 1'b1;
          end
          cp0_pc_error_d = (cp0_ex_code_d == EXC_ADEL) && (bus.ws_badvaddr == bus.ws_pc);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        state_d     = S_REDIRECT;
        ws_cancel_d = 1'b1;
        flush_d     = 1'b1;
        flush_pc_d  = cp0_eret_q ? bus.cp0_epc : EX_VECTOR;
      end
      S_REDIRECT: begin
        if (bus.flush_ready) begin
          state_d     = S_IDLE;
          ws_cancel_d = 1'b0;
          flush_d     = 1'b0;
        end else begin
          state_d     = S_REDIRECT;
          ws_cancel_d = 1'b1;
          flush_d     = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        ws_cancel_d = 1'b0;
        flush_d     = 1'b0;
      end
    endcase
  end

  assign bus.cp0_ex_code  = cp0_ex_code_q;
  assign bus.cp0_eret     = cp0_eret_q;
  assign bus.cp0_slot     = cp0_slot_q;
  assign bus.cp0_pc_error = cp0_pc_error_q;
  assign bus.cp0_wdata    = cp0_wdata_q;
  assign bus.cp0_badvaddr = cp0_badvaddr_q;
  assign bus.ws_cancel    = ws_cancel_q;
  assign bus.flush        = flush_q;
  assign bus.flush_pc     = flush_pc_q;

endmodule
